// File: rtl/timer_interrupts_pkg.sv
// ----------------------------------------------------------------------------
// timer_irq_pkg
// Shared constants for the timer/stopwatch interrupt block.
//   - Bit positions of each factor flag inside clock_factor / sw_factor.
//   - Widths of the factor groups and of the enable mask.
//   - bcd_wrap(): detects a BCD digit rolling over from 9 to 0.
// No ports (package).
// ----------------------------------------------------------------------------
package timer_irq_pkg;

    // Clock factor bit positions: clock_factor = {IT1, IT2, IT8, IT32}
    localparam int unsigned IT32 = 0;
    localparam int unsigned IT8  = 1;
    localparam int unsigned IT2  = 2;
    localparam int unsigned IT1  = 3;

    // Stopwatch factor bit positions: sw_factor = {ISW1, ISW0}
    localparam int unsigned ISW0 = 0;
    localparam int unsigned ISW1 = 1;

    // Field widths
    localparam int unsigned ClockFactorW = 4;
    localparam int unsigned SwFactorW    = 2;
    localparam int unsigned MaskW        = ClockFactorW + SwFactorW;
    localparam int unsigned ReadDataW    = ClockFactorW;
    localparam int unsigned BcdW         = 4;

    localparam logic [BcdW-1:0] BcdNine = 4'd9;
    localparam logic [BcdW-1:0] BcdZero = 4'd0;

    // True when a BCD digit has just rolled over from 9 to 0.
    function automatic logic bcd_wrap(input logic [BcdW-1:0] prev,
                                      input logic [BcdW-1:0] cur);
        return (prev == BcdNine) && (cur == BcdZero);
    endfunction

endpackage

// File: rtl/timer_interrupts_if.sv
// ----------------------------------------------------------------------------
// timer_interrupts_if
// CPU-side register bus of the timer interrupt block.
//   read_clock_factor : CPU -> block, single-cycle read/clear of clock flags
//   read_sw_factor    : CPU -> block, single-cycle read/clear of stopwatch flags
//   write_mask        : CPU -> block, mask write strobe
//   mask_data [5:0]   : CPU -> block, mask write data ([3:0] clock, [5:4] sw)
//   clock_factor [3:0]: block -> CPU, {IT1, IT2, IT8, IT32} sticky flags
//   sw_factor [1:0]   : block -> CPU, {ISW1, ISW0} sticky flags
//   mask [5:0]        : block -> CPU, current enable mask
//   read_data [3:0]   : block -> CPU, registered factor read result
//   irq               : block -> CPU, registered interrupt request
// Modports: master (CPU), slave (timer_interrupts).
// ----------------------------------------------------------------------------
interface timer_interrupts_if;
    import timer_irq_pkg::*;

    logic                    read_clock_factor;
    logic                    read_sw_factor;
    logic                    write_mask;
    logic [MaskW-1:0]        mask_data;
    logic [ClockFactorW-1:0] clock_factor;
    logic [SwFactorW-1:0]    sw_factor;
    logic [MaskW-1:0]        mask;
    logic [ReadDataW-1:0]    read_data;
    logic                    irq;

    modport master (
        output read_clock_factor,
        output read_sw_factor,
        output write_mask,
        output mask_data,
        input  clock_factor,
        input  sw_factor,
        input  mask,
        input  read_data,
        input  irq
    );

    modport slave (
        input  read_clock_factor,
        input  read_sw_factor,
        input  write_mask,
        input  mask_data,
        output clock_factor,
        output sw_factor,
        output mask,
        output read_data,
        output irq
    );

endinterface

// File: rtl/timer_interrupts_factor_flag.sv
// ----------------------------------------------------------------------------
// factor_flag
// One sticky interrupt factor: set by a single-cycle event, cleared by a
// CPU read strobe. When set and clear coincide, set wins so no event is lost.
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset (flag -> 0)
//   set     : event pulse, flag reads 1 from the next cycle
//   clr     : read strobe, flag reads 0 from the next cycle unless set
//   flag    : registered flag value
// ----------------------------------------------------------------------------
module factor_flag (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_d, flag_q;

    always_comb begin
        flag_d = flag_q;
        if (clr) begin
            flag_d = 1'b0;
        end
        // Set is evaluated last so it overrides a coincident clear.
        if (set) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/timer_interrupts.sv
// ----------------------------------------------------------------------------
// timer_interrupts
// Collects interrupt factors from the divided clock timers (falling edges of
// the 32/8/2/1 Hz levels) and, optionally, from the stopwatch (BCD digit
// rollover 9 -> 0). Each factor is a sticky flag cleared by a CPU read; the
// masked OR of the flags drives a registered irq.
//
// Configuration macro: STOPWATCH_IRQ_EN
//   defined   : stopwatch flags, mask[5:4] and read_sw_factor are live.
//   undefined : sw_factor = 0, mask[5:4] = 0, stopwatch inputs ignored,
//               read_sw_factor returns 0 in read_data.
//
// Ports:
//   clk               : single clock
//   reset_n           : synchronous active-low reset
//   timer_32hz/8hz/2hz/1hz : divided clock-timer levels
//   reset_clock_timer : clock-timer reset strobe, suppresses edge detection
//   stopwatch_swl     : stopwatch 1/100 s BCD digit
//   stopwatch_swh     : stopwatch 1/10 s BCD digit
//   bus               : CPU register bus (timer_interrupts_if.slave)
// ----------------------------------------------------------------------------
module timer_interrupts
    import timer_irq_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            timer_32hz,
    input  logic            timer_8hz,
    input  logic            timer_2hz,
    input  logic            timer_1hz,
    input  logic            reset_clock_timer,
    input  logic [BcdW-1:0] stopwatch_swl,
    input  logic [BcdW-1:0] stopwatch_swh,
    timer_interrupts_if.slave bus
);

    // ------------------------------------------------------------------------
    // Clock-timer edge detection
    // ------------------------------------------------------------------------
    logic [ClockFactorW-1:0] timer_now;
    logic [ClockFactorW-1:0] timer_q;
    logic                    rct_q;
    logic                    suppress;
    logic [ClockFactorW-1:0] clk_edge;
    logic [ClockFactorW-1:0] clock_factor;

    always_comb begin
        timer_now       = '0;
        timer_now[IT32] = timer_32hz;
        timer_now[IT8]  = timer_8hz;
        timer_now[IT2]  = timer_2hz;
        timer_now[IT1]  = timer_1hz;
    end

    // The timer dividers are being reset: their outputs may drop for reasons
    // that are not real ticks, so ignore edges now and for one cycle after.
    assign suppress = reset_clock_timer | rct_q;
    assign clk_edge = timer_q & ~timer_now & {ClockFactorW{~suppress}};

    for (genvar i = 0; i < ClockFactorW; i++) begin : g_clk_flag
        factor_flag u_flag (
            .clk     (clk),
            .reset_n (reset_n),
            .set     (clk_edge[i]),
            .clr     (bus.read_clock_factor),
            .flag    (clock_factor[i])
        );
    end

    // ------------------------------------------------------------------------
    // Stopwatch rollover flags and mask write data
    // ------------------------------------------------------------------------
    logic [SwFactorW-1:0] sw_factor;
    logic [MaskW-1:0]     mask_wr_data;

`ifdef STOPWATCH_IRQ_EN
    logic [BcdW-1:0]      swl_q, swh_q;
    logic [SwFactorW-1:0] sw_wrap;

    always_comb begin
        sw_wrap       = '0;
        sw_wrap[ISW0] = bcd_wrap(swl_q, stopwatch_swl);
        sw_wrap[ISW1] = bcd_wrap(swh_q, stopwatch_swh);
    end

    // History loads the live digits in reset so no rollover is seen at exit.
    always_ff @(posedge clk) begin
        swl_q <= stopwatch_swl;
        swh_q <= stopwatch_swh;
    end

    for (genvar i = 0; i < SwFactorW; i++) begin : g_sw_flag
        factor_flag u_flag (
            .clk     (clk),
            .reset_n (reset_n),
            .set     (sw_wrap[i]),
            .clr     (bus.read_sw_factor),
            .flag    (sw_factor[i])
        );
    end

    assign mask_wr_data = bus.mask_data;
`else
    logic unused_sw;

    assign unused_sw    = ^{stopwatch_swl, stopwatch_swh,
                            bus.mask_data[MaskW-1:ClockFactorW]};
    assign sw_factor    = '0;
    assign mask_wr_data = {{SwFactorW{1'b0}}, bus.mask_data[ClockFactorW-1:0]};
`endif

    // ------------------------------------------------------------------------
    // Mask, read data and irq registers
    // ------------------------------------------------------------------------
    logic [MaskW-1:0]     mask_d, mask_q;
    logic [ReadDataW-1:0] read_data_d, read_data_q;
    logic                 irq_d, irq_q;

    always_comb begin
        mask_d = mask_q;
        if (bus.write_mask) begin
            mask_d = mask_wr_data;
        end
    end

    // Flags are sampled before the coincident clear lands, so the CPU sees
    // every factor that was pending. Clock group wins on a double read.
    always_comb begin
        read_data_d = read_data_q;
        if (bus.read_clock_factor) begin
            read_data_d = clock_factor;
        end else if (bus.read_sw_factor) begin
            read_data_d = {{(ReadDataW - SwFactorW){1'b0}}, sw_factor};
        end
    end

    assign irq_d = |({sw_factor, clock_factor} & mask_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q     <= timer_now;
            rct_q       <= 1'b0;
            mask_q      <= '0;
            read_data_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            timer_q     <= timer_now;
            rct_q       <= reset_clock_timer;
            mask_q      <= mask_d;
            read_data_q <= read_data_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.clock_factor = clock_factor;
    assign bus.sw_factor    = sw_factor;
    assign bus.mask         = mask_q;
    assign bus.read_data    = read_data_q;
    assign bus.irq          = irq_q;

endmodule

// File: doc/timer_interrupts.md
TIMER_INTERRUPTS -- requirements
Module: timer_interrupts

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk in 1, the single clock; reset_n in 1, synchronous active-low reset.
REQ-002 The block SHALL have the timer inputs timer_32hz, timer_8hz, timer_2hz and timer_1hz: in 1 each, divided clock-timer levels.
REQ-003 The block SHALL have the input reset_clock_timer: in 1, the clock-timer reset strobe.
REQ-004 The block SHALL have the stopwatch inputs stopwatch_swl and stopwatch_swh: in 4 each, stopwatch BCD digits (1/100 s and 1/10 s).
REQ-005 The block SHALL have the CPU strobes read_clock_factor and read_sw_factor: in 1 each, single-cycle CPU factor-register reads.
REQ-006 The block SHALL have write_mask in 1 and mask_data in 6: a CPU mask write strobe with its data ([3:0] clock, [5:4] stopwatch).
REQ-007 The block SHALL have clock_factor out 4: {IT1, IT2, IT8, IT32} sticky factor flags.
REQ-008 The block SHALL have sw_factor out 2: {ISW1, ISW0} sticky stopwatch factor flags.
REQ-009 The block SHALL have mask out 6, the current enable mask, and read_data out 4, the registered factor read result.
REQ-010 The block SHALL have irq out 1, the registered interrupt request level.

Function
REQ-011 Each clock factor bit SHALL set on the clk cycle after a 1->0 transition of its timer input, detected against a one-cycle delayed copy.
REQ-012 ISW0 SHALL set when stopwatch_swl changes from 9 to 0; ISW1 SHALL set when stopwatch_swh changes from 9 to 0; other digit changes SHALL NOT set a flag.
REQ-013 A read strobe in cycle N SHALL load read_data at N+1 with the addressed flags as of cycle N, zero-extended for sw_factor.
REQ-014 A read strobe in cycle N SHALL clear the addressed flags at N+1.
REQ-015 read_data SHALL hold its value until the next read strobe.
REQ-016 If a set event and a clear of the same flag coincide, set SHALL win and read_data SHALL show the pre-clear value.
REQ-017 Simultaneous read_clock_factor and read_sw_factor SHALL clear both groups, with read_data taking the clock group.
REQ-018 While reset_clock_timer is high, and for one cycle after, clock-factor edge detection SHALL be suppressed, with no spurious flags.
REQ-019 write_mask SHALL load mask from mask_data on the next cycle, with flags unaffected.
REQ-020 irq SHALL be registered as OR({sw_factor, clock_factor} & mask), giving a one-cycle latency from flag or mask change.
REQ-021 A flag already set SHALL stay set on further edges, with no counting and no overflow.

Reset
REQ-022 On clk with reset_n low, clock_factor, sw_factor, mask, read_data and irq SHALL all be 0.
REQ-023 On clk with reset_n low, the edge-history registers SHALL load the current input values, so that no edge is detected on the first cycle after reset.
REQ-024 Reset asserted mid-read SHALL take priority, so that read_data is 0.

Configuration
REQ-025 With STOPWATCH_IRQ_EN defined, REQ-012 SHALL apply.
REQ-026 Without STOPWATCH_IRQ_EN, sw_factor SHALL be constant 0, mask[5:4] SHALL read 0, stopwatch inputs SHALL be ignored, and read_sw_factor reads SHALL return 0.

Structure
REQ-027 The package timer_irq_pkg SHALL hold the factor bit-index constants (IT32=0, IT8=1, IT2=2, IT1=3, ISW0=0, ISW1=1) and the mask field widths.
REQ-028 A sub-module factor_flag SHALL implement one edge-set/read-clear sticky flag with set priority, instantiated per factor.

Verification
REQ-029 Toggle timer_1hz 1->0 with mask=6'b001000 -> clock_factor=4'b1000 one cycle later and irq=1 the cycle after.
REQ-030 Pulse read_clock_factor with clock_factor=4'b1010 -> read_data=4'b1010, clock_factor=0 and irq falls one cycle later.
REQ-031 Assert a timer_8hz falling edge in the same cycle as read_clock_factor, with IT8 already set -> read_data[1]=1 and IT8 remains 1.
REQ-032 Hold reset_clock_timer while all timer inputs drop 1->0 -> clock_factor stays 0.
REQ-033 With STOPWATCH_IRQ_EN, step swl 8->9->0 and swh 9->0 in the same cycle -> sw_factor=2'b11; a read returns read_data=4'b0011; without the macro, sw_factor stays 0.
REQ-034 Assert reset_n low for one cycle while flags=4'b1111 and mask=6'h3F -> all outputs are 0 and there is no flag on the following cycle with inputs steady low.
